neuron_sequencer: RTL and testbench

//  Sequences one perceptron evaluation over the memory-mapped register bank: y = b + sum(x_i ? w_i : 0).

---
 rtl/nn_pkg.sv | 30 +++
 rtl/neuron_acc.sv | 31 +++
 rtl/neuron_sequencer.sv | 109 ++++++++++
 tb/tb_neuron_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants, state encoding and sign-extension helper for the perceptron block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_pkg;

  localparam int N_COEF = 20;
  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(N_COEF);
  localparam int ACC_W  = DATA_W + $clog2(N_COEF + 1);

  // Register bank map: coefficients, offset, input vector, start strobe
  localparam logic [11:0] ADDR_COEF0     = 12'h800;
  localparam logic [11:0] ADDR_COEF_LAST = 12'h84C;
  localparam logic [11:0] ADDR_OFFSET    = 12'h850;
  localparam logic [11:0] ADDR_INPUT     = 12'h854;
  localparam logic [11:0] ADDR_START     = 12'h858;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ACCUM = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM
  } state_t;

  function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] d);
    return {{(ACC_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

endpackage

// File: rtl/neuron_acc.sv
// Signed accumulator: load with a sign-extended offset, or add a gated sign-extended term.
// Latency: 1 cycle per operation; sum is the combinational acc + gated term.
// Backpressure: none; the sequencer drives load/add every cycle it needs them.
module neuron_acc
  import nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              add,
  input  logic              gate,
  input  logic [DATA_W-1:0] load_val,
  input  logic [DATA_W-1:0] term_val,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0] term;

  // A term contributes only when its input-vector bit is set
  assign term = gate ? sext(term_val) : '0;
  assign sum  = acc + term;

  // Load has priority so a new evaluation always starts from the offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (load) acc <= sext(load_val);
    else if (add)  acc <= sum;
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Sequences one perceptron evaluation y = b + sum(x_i ? w_i : 0) over the coefficient bank.
// Latency: Start at E0 -> Done pulse after E(N_COEF); Busy high for N_COEF cycles.
// Backpressure: none; Start while busy is dropped, Abort cancels a run without Done.
module neuron_sequencer
  import nn_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [N_COEF-1:0] InputVector,
  input  logic [DATA_W-1:0] OffsetData,
  output logic [IDX_W-1:0]  CoeffSel,
  input  logic [DATA_W-1:0] CoeffData,
  output logic              Busy,
  output logic              Done,
  output logic [ACC_W-1:0]  Result,
  output logic              Activation
);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  sel_nxt;
  logic              busy_nxt, done_nxt, act_nxt;
  logic [ACC_W-1:0]  result_nxt;
  logic [N_COEF-1:0] vec;
  logic              acc_load, acc_add;
  logic [ACC_W-1:0]  acc, acc_sum;

  neuron_acc u_acc (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (acc_load),
    .add      (acc_add),
    .gate     (vec[CoeffSel]),
    .load_val (OffsetData),
    .term_val (CoeffData),
    .acc      (acc),
    .sum      (acc_sum)
  );

  // State, index counter and published outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      CoeffSel   <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Result     <= '0;
      Activation <= 1'b1;
    end else begin
      state      <= state_nxt;
      CoeffSel   <= sel_nxt;
      Busy       <= busy_nxt;
      Done       <= done_nxt;
      Result     <= result_nxt;
      Activation <= act_nxt;
    end
  end

  // Input vector snapshot taken at Start so host writes mid-run are harmless
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)      vec <= '0;
    else if (acc_load) vec <= InputVector;
  end

  // Next-state and control decode; Done is a one-cycle pulse by default
  always_comb begin
    state_nxt  = state;
    sel_nxt    = CoeffSel;
    busy_nxt   = Busy;
    done_nxt   = 1'b0;
    result_nxt = Result;
    act_nxt    = Activation;
    acc_load   = 1'b0;
    acc_add    = 1'b0;
    case (state)
      IDLE: begin
        // Start beats a coincident Abort; Abort alone has nothing to cancel
        if (Start) begin
          acc_load  = 1'b1;
          sel_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (Abort) begin
          sel_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          acc_add = 1'b1;
          if (CoeffSel == IDX_W'(N_COEF - 1)) begin
            result_nxt = acc_sum;
            act_nxt    = ~acc_sum[ACC_W-1];
            done_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            sel_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            sel_nxt = CoeffSel + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed-vector bench for neuron_sequencer with a behavioural coefficient bank.
// Latency: checks Done timing relative to the Start edge.
// Backpressure: exercises Start-while-busy, Abort and mid-run reset.
module tb_neuron_sequencer;
  import nn_pkg::*;

  logic              Clk;
  logic              Reset_n;
  logic              Start;
  logic              Abort;
  logic [N_COEF-1:0] InputVector;
  logic [DATA_W-1:0] OffsetData;
  logic [IDX_W-1:0]  CoeffSel;
  logic [DATA_W-1:0] CoeffData;
  logic              Busy;
  logic              Done;
  logic [ACC_W-1:0]  Result;
  logic              Activation;

  logic [DATA_W-1:0] coef [32];
  int n_checks;
  int n_errors;
  int first_done, last_done, done_cnt, busy_cnt, sel_err;

  assign CoeffData = coef[CoeffSel];

  neuron_sequencer dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Abort       (Abort),
    .InputVector (InputVector),
    .OffsetData  (OffsetData),
    .CoeffSel    (CoeffSel),
    .CoeffData   (CoeffData),
    .Busy        (Busy),
    .Done        (Done),
    .Result      (Result),
    .Activation  (Activation)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic load_ramp;
    for (int i = 0; i < 32; i++) coef[i] = DATA_W'(i + 1);
  endtask

  // Pulse Start (optionally with Abort), then run len cycles with optional
  // Start re-pulse, Abort, and input/offset disturbance at given cycles.
  task automatic run_eval(input logic abort_start, input int len, input int start_at,
                          input int abort_at, input int toggle_at,
                          output int f_done, output int l_done, output int d_cnt,
                          output int b_cnt, output int s_err);
    Start = 1'b1;
    Abort = abort_start;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
    f_done = -1;
    l_done = -1;
    d_cnt  = 0;
    b_cnt  = int'(Busy);
    s_err  = (CoeffSel != '0) ? 1 : 0;
    for (int k = 1; k <= len; k++) begin
      Start = (k == start_at);
      Abort = (k == abort_at);
      if (k == toggle_at) begin
        InputVector = ~InputVector;
        OffsetData  = 32'd1000;
      end
      tick();
      if (Done) begin
        d_cnt++;
        if (f_done < 0) f_done = k;
        l_done = k;
      end
      if (Busy) b_cnt++;
      if (Busy && k < N_COEF && int'(CoeffSel) != k) s_err++;
    end
    Start = 1'b0;
    Abort = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    Reset_n     = 1'b0;
    Start       = 1'b0;
    Abort       = 1'b0;
    InputVector = '0;
    OffsetData  = '0;
    load_ramp();

    // Reset values
    #12;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_act", 64'(Activation), 64'd1);
    chk("rst_sel", 64'(CoeffSel), 64'd0);
    Reset_n = 1'b1;
    tick();

    // w_i=i+1, all inputs on, offset -100: 210-100 = 110
    InputVector = '1;
    OffsetData  = -32'sd100;
    run_eval(1'b0, 22, -1, -1, -1, first_done, last_done, done_cnt, busy_cnt, sel_err);
    chk("basic_done_cyc", 64'(first_done), 64'd20);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);
    chk("basic_busy_cycles", 64'(busy_cnt), 64'd20);
    chk("basic_result", 64'(Result), 64'd110);
    chk("basic_act", 64'(Activation), 64'd1);
    chk("basic_done_low", 64'(Done), 64'd0);

    // Abort while idle changes nothing
    Abort = 1'b1;
    tick();
    tick();
    Abort = 1'b0;
    chk("idle_abort_busy", 64'(Busy), 64'd0);
    chk("idle_abort_result", 64'(Result), 64'd110);

    // No inputs: result is the offset alone, index walks 0..19
    InputVector = '0;
    run_eval(1'b0, 21, -1, -1, -1, first_done, last_done, done_cnt, busy_cnt, sel_err);
    chk("zero_vec_result", 64'(Result), 64'h1F_FFFF_FF9C);
    chk("zero_vec_act", 64'(Activation), 64'd0);
    chk("zero_vec_sel_order", 64'(sel_err), 64'd0);
    chk("zero_vec_done_cyc", 64'(first_done), 64'd20);

    // Most negative values everywhere: -21 * 2^31 without wrap
    for (int i = 0; i < 32; i++) coef[i] = 32'h8000_0000;
    InputVector = '1;
    OffsetData  = 32'h8000_0000;
    run_eval(1'b0, 21, -1, -1, -1, first_done, last_done, done_cnt, busy_cnt, sel_err);
    chk("min_result", 64'(Result), 64'h15_8000_0000);
    chk("min_act", 64'(Activation), 64'd0);

    // Start re-pulsed mid-run is ignored
    load_ramp();
    OffsetData = -32'sd100;
    run_eval(1'b0, 25, 5, -1, -1, first_done, last_done, done_cnt, busy_cnt, sel_err);
    chk("restart_ign_cnt", 64'(done_cnt), 64'd1);
    chk("restart_ign_cyc", 64'(first_done), 64'd20);
    chk("restart_ign_result", 64'(Result), 64'd110);

    // Start during the Done cycle launches a second run
    run_eval(1'b0, 45, 21, -1, -1, first_done, last_done, done_cnt, busy_cnt, sel_err);
    chk("b2b_done_cnt", 64'(done_cnt), 64'd2);
    chk("b2b_first", 64'(first_done), 64'd20);
    chk("b2b_second", 64'(last_done), 64'd41);

    // Abort at cycle 10: no Done, previous Result kept
    InputVector = '0;
    OffsetData  = 32'd7;
    run_eval(1'b0, 25, -1, 10, -1, first_done, last_done, done_cnt, busy_cnt, sel_err);
    chk("abort_done_cnt", 64'(done_cnt), 64'd0);
    chk("abort_busy_cycles", 64'(busy_cnt), 64'd10);
    chk("abort_result_held", 64'(Result), 64'd110);
    chk("abort_act_held", 64'(Activation), 64'd1);

    // Start and Abort together in IDLE: Start wins
    InputVector = '1;
    OffsetData  = '0;
    run_eval(1'b1, 22, -1, -1, -1, first_done, last_done, done_cnt, busy_cnt, sel_err);
    chk("start_abort_cyc", 64'(first_done), 64'd20);
    chk("start_abort_result", 64'(Result), 64'd210);

    // Reset asserted at cycle 7 of a run
    OffsetData = -32'sd100;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    Reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_result", 64'(Result), 64'd0);
    chk("midrst_act", 64'(Activation), 64'd1);
    chk("midrst_sel", 64'(CoeffSel), 64'd0);
    #2;
    Reset_n = 1'b1;
    tick();
    chk("midrst_no_done", 64'(Done), 64'd0);
    run_eval(1'b0, 22, -1, -1, -1, first_done, last_done, done_cnt, busy_cnt, sel_err);
    chk("post_rst_cyc", 64'(first_done), 64'd20);
    chk("post_rst_result", 64'(Result), 64'd110);

    // Inputs 0..3 on (1+2+3+4) plus offset 5; disturbance at cycle 3 ignored
    InputVector = 20'h0000F;
    OffsetData  = 32'd5;
    run_eval(1'b0, 22, -1, -1, 3, first_done, last_done, done_cnt, busy_cnt, sel_err);
    chk("snapshot_result", 64'(Result), 64'd15);
    chk("snapshot_act", 64'(Activation), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
